// File: rtl/cr_kme_fifo_pkg.sv
// cr_kme_fifo_pkg: shared constants and helpers for the KME generic FIFO.
//   - Default parameter values for cr_kme_fifo_gen.
//   - cnt_w():   width of an occupancy counter able to hold 0..depth.
//   - ptr_inc(): pointer increment that wraps at depth-1. Depth need not be a power of two.
package cr_kme_fifo_pkg;

   localparam int unsigned DefaultWidth       = 8;
   localparam int unsigned DefaultDepth       = 16;
   localparam int unsigned DefaultStallThresh = 1;

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Explicit compare keeps wrap correct for depths that are not a power of two.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/cr_kme_fifo_mem.sv
// cr_kme_fifo_mem: DEPTH x WIDTH register array for cr_kme_fifo_gen.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset (clears every entry to 0)
//   we/waddr/wdata  - single synchronous write port
//   raddr/rdata     - single asynchronous read port
module cr_kme_fifo_mem #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cr_kme_fifo_gen.sv
// cr_kme_fifo_gen: parametrised first-word-fall-through FIFO for the KME datapath.
// Parameters: WIDTH (data bits), DEPTH (entries, >= 2, any value), STALL_THRESH (stall when
// free_slots <= STALL_THRESH).
// Ports:
//   clk, rst                - clock; asynchronous active-high reset
//   clear                   - synchronous flush (wins over same-cycle read/write)
//   fifo_in, fifo_in_valid  - write data / request
//   fifo_in_stall_override  - forces fifo_in_stall high combinationally
//   fifo_in_stall           - advisory back-pressure; writes are still taken while not full
//   fifo_out, fifo_out_valid, fifo_out_ack - head data, non-empty flag, consume strobe
//   used_slots, free_slots  - occupancy and remaining space
//   fifo_overflow/underflow - registered one-cycle pulses for dropped write / ack while empty
//   hwm, hwm_clr            - occupancy high-water mark and its synchronous clear
// Optional feature: define CR_KME_FIFO_HWM_EN to build the high-water-mark tracker; otherwise
// hwm is tied to 0 and hwm_clr is ignored.
module cr_kme_fifo_gen
   import cr_kme_fifo_pkg::*;
#(
   parameter int unsigned WIDTH        = DefaultWidth,
   parameter int unsigned DEPTH        = DefaultDepth,
   parameter int unsigned STALL_THRESH = DefaultStallThresh,
   localparam int unsigned CNT_W       = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [WIDTH-1:0] fifo_in,
   input  logic             fifo_in_valid,
   input  logic             fifo_in_stall_override,
   output logic             fifo_in_stall,
   output logic [WIDTH-1:0] fifo_out,
   output logic             fifo_out_valid,
   input  logic             fifo_out_ack,
   output logic [CNT_W-1:0] used_slots,
   output logic [CNT_W-1:0] free_slots,
   output logic             fifo_overflow,
   output logic             fifo_underflow,
   output logic [CNT_W-1:0] hwm,
   input  logic             hwm_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ThreshCnt = CNT_W'(STALL_THRESH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] used_q, used_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             full, empty, ren, wen, mem_we;

   assign full           = (used_q == DepthCnt);
   assign empty          = (used_q == '0);
   assign fifo_out_valid = !empty;
   assign ren            = fifo_out_valid & fifo_out_ack;
   // A read in the same cycle frees the slot, so a write into a full FIFO is still accepted.
   assign wen            = fifo_in_valid & (!full | ren);
   assign mem_we         = wen & !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      used_d   = used_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         used_d   = '0;
      end else begin
         if (wen) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
         if (ren) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
         if (wen && !ren) begin
            used_d = used_q + 1'b1;
         end else if (ren && !wen) begin
            used_d = used_q - 1'b1;
         end
         ovf_d = fifo_in_valid & full & !ren;
         unf_d = fifo_out_ack & empty;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         used_q   <= used_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   cr_kme_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (fifo_in),
      .raddr (rd_ptr_q),
      .rdata (fifo_out)
   );

   assign used_slots     = used_q;
   assign free_slots     = DepthCnt - used_q;
   assign fifo_in_stall  = (free_slots <= ThreshCnt) | fifo_in_stall_override;
   assign fifo_overflow  = ovf_q;
   assign fifo_underflow = unf_q;

`ifdef CR_KME_FIFO_HWM_EN
   logic [CNT_W-1:0] hwm_q;

   // Tracks the registered occupancy, so it trails used_slots by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hwm_q <= '0;
      end else if (hwm_clr) begin
         hwm_q <= '0;
      end else if (used_q > hwm_q) begin
         hwm_q <= used_q;
      end
   end

   assign hwm = hwm_q;
`else
   logic unused_hwm_clr;
   assign unused_hwm_clr = hwm_clr;
   assign hwm            = '0;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_gen.sv
// Self-checking bench for cr_kme_fifo_gen (WIDTH=8, DEPTH=4, STALL_THRESH=1).
// The reference model is a byte queue updated once per clock edge from the FIFO's rules.
module tb_cr_kme_fifo_gen;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned STALL = 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef CR_KME_FIFO_HWM_EN
   localparam bit HwmOn = 1'b1;
`else
   localparam bit HwmOn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] fifo_in = '0;
   logic             fifo_in_valid = 1'b0;
   logic             override = 1'b0;
   logic             fifo_in_stall;
   logic [WIDTH-1:0] fifo_out;
   logic             fifo_out_valid;
   logic             fifo_out_ack = 1'b0;
   logic [CNT_W-1:0] used_slots, free_slots, hwm;
   logic             fifo_overflow, fifo_underflow;
   logic             hwm_clr = 1'b0;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   logic [WIDTH-1:0] q[$];
   bit               m_ovf, m_unf;
   int               m_hwm;

   cr_kme_fifo_gen #(
      .WIDTH        (WIDTH),
      .DEPTH        (DEPTH),
      .STALL_THRESH (STALL)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .clear                  (clear),
      .fifo_in                (fifo_in),
      .fifo_in_valid          (fifo_in_valid),
      .fifo_in_stall_override (override),
      .fifo_in_stall          (fifo_in_stall),
      .fifo_out               (fifo_out),
      .fifo_out_valid         (fifo_out_valid),
      .fifo_out_ack           (fifo_out_ack),
      .used_slots             (used_slots),
      .free_slots             (free_slots),
      .fifo_overflow          (fifo_overflow),
      .fifo_underflow         (fifo_underflow),
      .hwm                    (hwm),
      .hwm_clr                (hwm_clr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_hwm = 0;
   endtask

   // One clock edge of the intended behaviour, using pre-edge occupancy.
   task automatic model_edge(input bit iv, input logic [WIDTH-1:0] d, input bit ack,
                             input bit clr, input bit hc);
      int  n = q.size();
      bit  r = (n > 0) && ack;
      bit  w = iv && ((n < int'(DEPTH)) || r);
      if (HwmOn) begin
         if (hc) m_hwm = 0;
         else if (n > m_hwm) m_hwm = n;
      end
      if (clr) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         m_ovf = iv && (n == int'(DEPTH)) && !r;
         m_unf = ack && (n == 0);
         if (r) void'(q.pop_front());
         if (w) q.push_back(d);
      end
   endtask

   // Drive one cycle of inputs, advance through the edge, sample 1 time unit after it.
   task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ack,
                        input bit clr, input bit hc);
      fifo_in_valid = iv;
      fifo_in       = d;
      fifo_out_ack  = ack;
      clear         = clr;
      hwm_clr       = hc;
      @(posedge clk);
      model_edge(iv, d, ack, clr, hc);
      #1;
      fifo_in_valid = 1'b0;
      fifo_out_ack  = 1'b0;
      clear         = 1'b0;
      hwm_clr       = 1'b0;
   endtask

   function automatic bit exp_stall();
      return ((int'(DEPTH) - q.size()) <= int'(STALL)) || override;
   endfunction

   task automatic test_reset();
      #3;
      tests++;
      if ({used_slots, free_slots, fifo_out_valid, fifo_overflow, fifo_underflow, fifo_out,
           hwm, fifo_in_stall} !== {CNT_W'(0), CNT_W'(DEPTH), 3'b000, 8'h00, CNT_W'(0), 1'b0}) begin
         fails++;
         $display("FAIL reset_state: used=%0d free=%0d valid=%b ovf=%b unf=%b out=%h hwm=%0d stall=%b",
                  used_slots, free_slots, fifo_out_valid, fifo_overflow, fifo_underflow,
                  fifo_out, hwm, fifo_in_stall);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
         tests++;
         if (used_slots !== CNT_W'(i + 1) || fifo_in_stall !== (i >= 2) || fifo_out !== 8'h11 ||
             fifo_out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fill_%0d: used=%0d stall=%b out=%h valid=%b, want used=%0d stall=%b out=11 valid=1",
                     i, used_slots, fifo_in_stall, fifo_out, fifo_out_valid, i + 1, (i >= 2));
         end
      end
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      tests++;
      if (fifo_overflow !== 1'b1 || used_slots !== CNT_W'(4)) begin
         fails++;
         $display("FAIL overflow_pulse: ovf=%b used=%0d, want ovf=1 used=4", fifo_overflow, used_slots);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tests++;
      if (fifo_overflow !== 1'b0) begin
         fails++;
         $display("FAIL overflow_one_cycle: ovf=%b, want 0", fifo_overflow);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (fifo_out !== vals[i] || fifo_out_valid !== 1'b1) begin
            fails++;
            $display("FAIL overflow_drain_%0d: out=%h valid=%b, want %h valid=1",
                     i, fifo_out, fifo_out_valid, vals[i]);
         end
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      tests++;
      if (fifo_out_valid !== 1'b0 || used_slots !== CNT_W'(0)) begin
         fails++;
         $display("FAIL overflow_empty: valid=%b used=%0d, want 0/0", fifo_out_valid, used_slots);
      end
   endtask

   task automatic test_full_write_ack();
      logic [WIDTH-1:0] vals [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      tests++;
      if (fifo_overflow !== 1'b0 || used_slots !== CNT_W'(4) || fifo_out !== 8'h22) begin
         fails++;
         $display("FAIL full_write_ack: ovf=%b used=%0d out=%h, want 0/4/22",
                  fifo_overflow, used_slots, fifo_out);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (fifo_out !== vals[i]) begin
            fails++;
            $display("FAIL wrap_drain_%0d: out=%h, want %h", i, fifo_out, vals[i]);
         end
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_underflow_override();
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tests++;
      if (fifo_underflow !== 1'b1 || used_slots !== CNT_W'(0) || free_slots !== CNT_W'(DEPTH)) begin
         fails++;
         $display("FAIL underflow_pulse: unf=%b used=%0d free=%0d, want 1/0/4",
                  fifo_underflow, used_slots, free_slots);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tests++;
      if (fifo_underflow !== 1'b0) begin
         fails++;
         $display("FAIL underflow_one_cycle: unf=%b, want 0", fifo_underflow);
      end
      override = 1'b1;
      #1;
      tests++;
      if (fifo_in_stall !== 1'b1) begin
         fails++;
         $display("FAIL override_on: stall=%b, want 1", fifo_in_stall);
      end
      override = 1'b0;
      #1;
      tests++;
      if (fifo_in_stall !== 1'b0) begin
         fails++;
         $display("FAIL override_off: stall=%b, want 0", fifo_in_stall);
      end
   endtask

   task automatic test_clear_and_rst();
      cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA4, 1'b0, 1'b1, 1'b0);
      tests++;
      if (used_slots !== CNT_W'(0) || fifo_out_valid !== 1'b0 || fifo_overflow !== 1'b0) begin
         fails++;
         $display("FAIL clear: used=%0d valid=%b ovf=%b, want 0/0/0",
                  used_slots, fifo_out_valid, fifo_overflow);
      end
      // Full FIFO, write without ack plus clear: the dropped write must not flag overflow.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hBF, 1'b0, 1'b1, 1'b0);
      tests++;
      if (fifo_overflow !== 1'b0 || used_slots !== CNT_W'(0)) begin
         fails++;
         $display("FAIL clear_full: ovf=%b used=%0d, want 0/0", fifo_overflow, used_slots);
      end
      cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
      fifo_in_valid = 1'b1;
      fifo_in       = 8'hC3;
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({used_slots, free_slots, fifo_out_valid, fifo_overflow, fifo_underflow, fifo_out,
           hwm, fifo_in_stall} !== {CNT_W'(0), CNT_W'(DEPTH), 3'b000, 8'h00, CNT_W'(0), 1'b0}) begin
         fails++;
         $display("FAIL async_rst: used=%0d free=%0d valid=%b ovf=%b unf=%b out=%h hwm=%0d stall=%b",
                  used_slots, free_slots, fifo_out_valid, fifo_overflow, fifo_underflow,
                  fifo_out, hwm, fifo_in_stall);
      end
      fifo_in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_hwm();
      cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tests++;
      if (hwm !== CNT_W'(HwmOn ? 3 : 0) || hwm !== CNT_W'(m_hwm)) begin
         fails++;
         $display("FAIL hwm_peak: hwm=%0d, want %0d", hwm, HwmOn ? 3 : 0);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tests++;
      if (hwm !== CNT_W'(0)) begin
         fails++;
         $display("FAIL hwm_clr: hwm=%0d, want 0", hwm);
      end
      cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tests++;
      if (hwm !== CNT_W'(HwmOn ? 1 : 0)) begin
         fails++;
         $display("FAIL hwm_retrack: hwm=%0d, want %0d", hwm, HwmOn ? 1 : 0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bit  iv  = 1'($urandom_range(0, 1));
         bit  ack = ($urandom_range(0, 2) != 0);
         bit  clr = ($urandom_range(0, 31) == 0);
         bit  hc  = ($urandom_range(0, 31) == 0);
         logic [WIDTH-1:0] d = 8'($urandom);
         override = ($urandom_range(0, 7) == 0);
         cycle(iv, d, ack, clr, hc);
         tests++;
         if ({used_slots, free_slots, fifo_out_valid, fifo_overflow, fifo_underflow,
              fifo_in_stall, hwm} !==
             {CNT_W'(q.size()), CNT_W'(int'(DEPTH) - q.size()), (q.size() > 0), m_ovf, m_unf,
              exp_stall(), CNT_W'(m_hwm)}) begin
            fails++;
            $display("FAIL random_%0d: used=%0d free=%0d valid=%b ovf=%b unf=%b stall=%b hwm=%0d, want used=%0d ovf=%b unf=%b stall=%b hwm=%0d",
                     i, used_slots, free_slots, fifo_out_valid, fifo_overflow, fifo_underflow,
                     fifo_in_stall, hwm, q.size(), m_ovf, m_unf, exp_stall(), m_hwm);
         end
         if (q.size() > 0) begin
            tests++;
            if (fifo_out !== q[0]) begin
               fails++;
               $display("FAIL random_data_%0d: out=%h, want %h", i, fifo_out, q[0]);
            end
         end
      end
      override = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_overflow();
      test_full_write_ack();
      test_underflow_override();
      test_clear_and_rst();
      test_hwm();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
